// File: rtl/ram_scan_ctrl.sv
// Read-modify-write scanner for the LPT3RAM: adds delta to every word
// and tracks the largest updated word and its address.
module ram_scan_ctrl #(
  parameter int data_width = 9,
  parameter int addr_width = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [data_width-1:0] delta,
  input  logic [data_width-1:0] mem_dout,
  output logic [addr_width-1:0] mem_addr,
  output logic                  mem_write,
  output logic [data_width-1:0] mem_din,
  output logic                  busy,
  output logic                  done,
  output logic [data_width-1:0] max_val,
  output logic [addr_width-1:0] max_addr
);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE,
    DONE
  } state_t;

  state_t state, state_nx;

  logic [data_width-1:0] delta_reg, delta_nx;
  logic [data_width-1:0] din_nx, max_val_nx, sum;
  logic [addr_width-1:0] addr_nx, max_addr_nx;

  always_comb begin
    state_nx    = state;
    delta_nx    = delta_reg;
    addr_nx     = mem_addr;
    din_nx      = mem_din;
    max_val_nx  = max_val;
    max_addr_nx = max_addr;
    sum         = mem_dout + delta_reg;
    unique case (state)
      IDLE: begin
        if (start) begin
          delta_nx    = delta;
          addr_nx     = '0;
          max_val_nx  = '0;
          max_addr_nx = '0;
          state_nx    = READ;
        end
      end
      READ: begin
        din_nx = sum;
        if (sum > max_val) begin
          max_val_nx  = sum;
          max_addr_nx = mem_addr;
        end
        state_nx = WRITE;
      end
      WRITE: begin
        if (&mem_addr) begin
          state_nx = DONE;
        end else begin
          addr_nx  = mem_addr + addr_width'(1);
          state_nx = READ;
        end
      end
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Moore outputs are registered from the next state so they align with it
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      delta_reg <= '0;
      mem_addr  <= '0;
      mem_din   <= '0;
      mem_write <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      max_val   <= '0;
      max_addr  <= '0;
    end else begin
      state     <= state_nx;
      delta_reg <= delta_nx;
      mem_addr  <= addr_nx;
      mem_din   <= din_nx;
      mem_write <= (state_nx == WRITE);
      busy      <= (state_nx == READ) || (state_nx == WRITE);
      done      <= (state_nx == DONE);
      max_val   <= max_val_nx;
      max_addr  <= max_addr_nx;
    end
  end

endmodule
